add128_rr_arbiter: RTL
======================

ADD128_RR_ARBITER -- requirements
Module: add128_rr_arbiter

Interface
REQ-001: The block SHALL take parameter NREQ, default 4: number of requesters sharing the adder; legal range 2..8.
REQ-002: The block SHALL take parameter W, default 128: operand and sum width in bits.
REQ-003: Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004: Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005: Port req_valid, input, NREQ: per-requester request valid.
REQ-006: Port req_ready, output, NREQ: per-requester accept strobe; at most one bit high per cycle.
REQ-007: Port req_a, input, NREQ*W: packed operand A; requester i occupies bits [i*W +: W].
REQ-008: Port req_b, input, NREQ*W: packed operand B, same packing as req_a.
REQ-009: Port req_cin, input, NREQ: per-requester carry-in.
REQ-010: Port rsp_valid, output, 1: result valid.
REQ-011: Port rsp_ready, input, 1: consumer accepts the result.
REQ-012: Port rsp_id, output, clog2(NREQ): index of the requester that owns the result.
REQ-013: Port rsp_sum, output, W: sum, modulo 2^W.
REQ-014: Port rsp_cout, output, 1: carry-out, i.e. bit W of a+b+cin.

Function
REQ-015: The block SHALL contain exactly one W-bit adder (a + b + cin -> {cout, sum}), shared by all requesters.
REQ-016: The FSM SHALL have three states: IDLE, CALC, RESP.
REQ-017: A request is accepted in a cycle when req_valid[i] and req_ready[i] are both high; this is legal only in IDLE, or in RESP in the same cycle that rsp_ready is high.
REQ-018: req_ready SHALL be combinational. In an accept-eligible cycle exactly one bit is high: the bit of the round-robin winner, and only if some req_valid bit is high. In all other cycles req_ready is zero.
REQ-019: Round-robin arbitration SHALL pick the first asserted req_valid bit, scanning from index last_grant+1 upward and wrapping modulo NREQ.
REQ-020: last_grant SHALL update to the winner's index on accept only.
REQ-021: On accept, req_a, req_b, req_cin and the winner index SHALL be captured into operand registers. Later changes on the request inputs have no effect on that transaction.
REQ-022: Accept -> CALC. On the next edge, CALC -> RESP and the adder output plus the captured id are loaded into registers that drive rsp_sum, rsp_cout and rsp_id.
REQ-023: rsp_valid SHALL be high exactly when the state is RESP. The first cycle it is high is 2 cycles after the accept edge.
REQ-024: In RESP, rsp_sum, rsp_cout and rsp_id SHALL hold stable while rsp_ready is low; there is no timeout.
REQ-025: In RESP with rsp_ready high:
- if a new request is accepted in the same cycle, the next state is CALC;
- otherwise the next state is IDLE.
REQ-026: Peak throughput SHALL be one result per 2 cycles.
REQ-027: rsp_ready while in IDLE or CALC SHALL be ignored.
REQ-028: A requester that drops req_valid before being granted SHALL simply not be selected; no request state is retained.
REQ-029: Arithmetic SHALL be unsigned, with wrap-around modulo 2^W and the overflow reported only on rsp_cout.

Reset
REQ-030: While rst_n is low, the block SHALL force:
- state = IDLE;
- rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0;
- operand registers = 0;
- last_grant = NREQ-1, so requester 0 has first priority.
REQ-031: Reset asserted mid-transaction (CALC or RESP) SHALL discard that transaction with no response issued. req_ready SHALL be 0 during reset.
REQ-032: After rst_n deasserts, the first accept is possible in the first cycle with a rising clk edge.

Verification
REQ-033: Single request:
- stimulus: rsp_ready tied high; requester 2 sends a = 2^128-1, b = 0, cin = 1;
- response: rsp_valid high 2 cycles after accept for exactly one cycle, with rsp_sum = 0, rsp_cout = 1, rsp_id = 2.
REQ-034: Round robin:
- stimulus: all 4 req_valid held high continuously, rsp_ready high;
- response: grant order 0,1,2,3,0,...; one result every 2 cycles; each rsp_id matches its operands.
REQ-035: Backpressure:
- stimulus: rsp_ready low for 10 cycles while in RESP, with operands changed after accept;
- response: rsp_* outputs stable and req_ready = 0 throughout; on rsp_ready high, the next accept happens in the same cycle.
REQ-036: Skipping and wrap:
- stimulus: only requesters 1 and 3 valid, last_grant = 3;
- response: grant 1, then 3, then 1.
REQ-037: Reset mid-operation:
- stimulus: rst_n pulsed low during CALC;
- response: no rsp_valid; outputs 0; next request from requester 0 wins over requester 3.
REQ-038: Random regression:
- stimulus: 1000 random {a, b, cin} with random requesters and random rsp_ready;
- response: every result equals the reference a+b+cin (sum and cout); no result is lost or duplicated.

Source files
------------

// File: rtl/add128_rr_arbiter.sv
// add128_rr_arbiter: round-robin arbiter sharing one W-bit adder among NREQ requesters.
// Request accept -> CALC -> RESP; a new request may be accepted in the cycle the response is taken.
module add128_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 128
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*W-1:0]       req_a,
   input  logic [NREQ*W-1:0]       req_b,
   input  logic [NREQ-1:0]         req_cin,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [W-1:0]            rsp_sum,
   output logic                    rsp_cout
);
   localparam int IW = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] last_q, last_d, id_q, id_d, rsp_id_q, rsp_id_d, win;
   logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic cin_q, cin_d, cout_q, cout_d, any, elig, accept;
   logic [W:0] add;
   // Descending scan so the closest index after last_q is the final assignment.
   always_comb begin
      win = '0;
      any = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req_valid[(int'(last_q) + k) % NREQ]) begin
            win = IW'((int'(last_q) + k) % NREQ);
            any = 1'b1;
         end
      end
   end
   always_comb begin
      elig      = rst_n && (state_q == IDLE || (state_q == RESP && rsp_ready));
      accept    = elig && any;
      req_ready = accept ? NREQ'(1) << win : '0;
      add       = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};
      state_d   = accept ? CALC : state_q == CALC ? RESP : (state_q == RESP && rsp_ready) ? IDLE : state_q;
      last_d    = accept ? win : last_q;
      a_d       = accept ? req_a[int'(win)*W +: W] : a_q;
      b_d       = accept ? req_b[int'(win)*W +: W] : b_q;
      cin_d     = accept ? req_cin[win] : cin_q;
      id_d      = accept ? win : id_q;
      sum_d     = state_q == CALC ? add[W-1:0] : sum_q;
      cout_d    = state_q == CALC ? add[W] : cout_q;
      rsp_id_d  = state_q == CALC ? id_q : rsp_id_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_q   <= IW'(NREQ - 1);
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
         id_q     <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         rsp_id_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cin_q    <= cin_d;
         id_q     <= id_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         rsp_id_q <= rsp_id_d;
      end
   end
   assign rsp_valid = state_q == RESP;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
   assign rsp_id    = rsp_id_q;
endmodule
